// File: rtl/div_seq_pkg.sv
// ============================================================================
// div_seq_pkg : shared divider opcodes and FSM state encoding
// Revision    : 1.0
// ============================================================================
`default_nettype none

package div_seq_pkg;

  localparam int DIV_OP_WIDTH = 2;

  // Matches the multiplier-extension decoder encoding
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIV  = 2'd0;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIVU = 2'd1;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REM  = 2'd2;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REMU = 2'd3;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = DIV_IDLE,
    S_CALC = DIV_CALC,
    S_DONE = DIV_DONE
  } div_state_e;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// div_step : one combinational restoring shift-compare-subtract step
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_qmsb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_sh;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  assign w_sh   = {i_rem[WIDTH-1:0], i_qmsb};
  assign w_diff = w_sh - {1'b0, i_divisor};
  // A set top bit would push the shifted value past any divisor
  assign w_ge   = i_rem[WIDTH] | (w_sh >= {1'b0, i_divisor});
  assign o_rem  = w_ge ? w_diff : w_sh;
  assign o_qbit = w_ge;

endmodule

`default_nettype wire

// File: rtl/div_seq.sv
// ============================================================================
// div_seq  : sequential radix-2 divider for DIV/DIVU/REM/REMU
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DIV_OP_WIDTH-1:0] divop,
  input  logic [WIDTH-1:0]        dividend,
  input  logic [WIDTH-1:0]        divisor,
  input  logic                    div_valid,
  output logic                    div_ready,
  output logic [WIDTH-1:0]        div_result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] C_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       r_state, w_next;
  logic [CW-1:0]    r_count;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_divisor;
  logic             r_neg_q, r_neg_r, r_is_rem;
  logic             r_ready;
  logic [WIDTH-1:0] r_result;

  logic             w_signed, w_is_rem, w_div_zero, w_ovf, w_special;
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_special_result;
  logic [WIDTH:0]   w_rem;
  logic             w_qbit;
  logic [WIDTH-1:0] w_q_final, w_r_final, w_q_signed, w_r_signed, w_calc_result;
  logic             w_last;

  assign w_signed   = (divop == DIV_OP_DIV) || (divop == DIV_OP_REM);
  assign w_is_rem   = (divop == DIV_OP_REM) || (divop == DIV_OP_REMU);
  assign w_div_zero = (divisor == '0);
  assign w_ovf      = w_signed && (dividend == C_MIN_NEG) && (divisor == '1);
  assign w_special  = w_div_zero || w_ovf;
  assign w_a_neg    = w_signed & dividend[WIDTH-1];
  assign w_b_neg    = w_signed & divisor[WIDTH-1];
  assign w_abs_a    = w_a_neg ? (~dividend + 1'b1) : dividend;
  assign w_abs_b    = w_b_neg ? (~divisor + 1'b1) : divisor;

  // Divide-by-zero returns the raw dividend as remainder, never its magnitude
  assign w_special_result = w_div_zero ? (w_is_rem ? dividend : '1)
                                       : (w_is_rem ? '0 : C_MIN_NEG);

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_qmsb    (r_q[WIDTH-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_rem),
    .o_qbit    (w_qbit)
  );

  assign w_last        = (r_count == CW'(WIDTH - 1));
  assign w_q_final     = {r_q[WIDTH-2:0], w_qbit};
  assign w_r_final     = w_rem[WIDTH-1:0];
  assign w_q_signed    = r_neg_q ? (~w_q_final + 1'b1) : w_q_final;
  assign w_r_signed    = r_neg_r ? (~w_r_final + 1'b1) : w_r_final;
  assign w_calc_result = r_is_rem ? w_r_signed : w_q_signed;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (div_valid) w_next = w_special ? S_DONE : S_CALC;
      S_CALC: begin
        if (!div_valid)  w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_is_rem  <= 1'b0;
      r_ready   <= 1'b0;
      r_result  <= '0;
    end else begin
      r_ready <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (div_valid) begin
            r_is_rem  <= w_is_rem;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_rem     <= '0;
            r_q       <= w_abs_a;
            r_divisor <= w_abs_b;
            r_count   <= '0;
            if (w_special) r_result <= w_special_result;
          end
        end
        S_CALC: begin
          if (div_valid) begin
            r_rem   <= w_rem;
            r_q     <= w_q_final;
            r_count <= r_count + 1'b1;
            if (w_last) r_result <= w_calc_result;
          end
        end
        default: ;
      endcase
    end
  end

  assign div_ready  = r_ready;
  assign div_result = r_result;

endmodule

`default_nettype wire
